// File: rtl/matmul_mac_engine.sv
// rtl/matmul_mac_engine.sv - sequential C = A x B engine writing C row-major to result SRAM
module matmul_mac_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mac_valid,
  output logic              mac_ready,
  input  logic              override_dims,
  input  logic [DATA_W-1:0] override_a_dims,
  input  logic [DATA_W-1:0] override_b_dims,
  input  logic [ADDR_W-1:0] a_base_addr,
  input  logic [ADDR_W-1:0] b_base_addr,
  input  logic [ADDR_W-1:0] result_base_addr,
  output logic [ADDR_W-1:0] a_read_addr,
  input  logic [DATA_W-1:0] a_read_data,
  output logic [ADDR_W-1:0] b_read_addr,
  input  logic [DATA_W-1:0] b_read_data,
  output logic              result_we,
  output logic [ADDR_W-1:0] result_waddr,
  output logic [DATA_W-1:0] result_wdata,
  output logic [DIM_W-1:0]  a_rows,
  output logic [DIM_W-1:0]  a_cols,
  output logic [DIM_W-1:0]  b_rows,
  output logic [DIM_W-1:0]  b_cols,
  output logic [DIM_W-1:0]  cur_row,
  output logic [DIM_W-1:0]  cur_col
);

  localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIM_RD,
    S_DIM_LATCH,
    S_RUN,
    S_ACC,
    S_WRITE
  } state_t;

  state_t            state_q, state_d;
  logic              mac_ready_q, mac_ready_d;
  logic [ADDR_W-1:0] a_read_addr_q, a_read_addr_d;
  logic [ADDR_W-1:0] b_read_addr_q, b_read_addr_d;
  logic              result_we_q, result_we_d;
  logic [ADDR_W-1:0] result_waddr_q, result_waddr_d;
  logic [DATA_W-1:0] result_wdata_q, result_wdata_d;
  logic [DIM_W-1:0]  a_rows_q, a_rows_d;
  logic [DIM_W-1:0]  a_cols_q, a_cols_d;
  logic [DIM_W-1:0]  b_rows_q, b_rows_d;
  logic [DIM_W-1:0]  b_cols_q, b_cols_d;
  logic [DIM_W-1:0]  cur_row_q, cur_row_d;
  logic [DIM_W-1:0]  cur_col_q, cur_col_d;
  logic [DIM_W-1:0]  k_q, k_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  // a_row: address of A(m,0); b_col: address of B(0,n)
  logic [ADDR_W-1:0] a_row_q, a_row_d;
  logic [ADDR_W-1:0] b_col_q, b_col_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;
  logic [ADDR_W-1:0] b_base_q, b_base_d;
  logic [ADDR_W-1:0] res_base_q, res_base_d;

  logic              start_elem;
  logic [DATA_W-1:0] prod;
  logic [ADDR_W-1:0] k_step;
  logic [DIM_W-1:0]  ovr_m, ovr_k, ovr_n;
  logic [DIM_W-1:0]  rd_m, rd_k, rd_n;

  // Signed product truncated to DATA_W; low bits wrap like the accumulator
  assign prod   = $signed(a_read_data) * $signed(b_read_data);
  assign k_step = ADDR_W'(a_cols_q);
  assign ovr_m  = override_a_dims[DIM_W +: DIM_W];
  assign ovr_k  = override_a_dims[DIM_W-1:0];
  assign ovr_n  = override_b_dims[DIM_W-1:0];
  assign rd_m   = a_read_data[DIM_W +: DIM_W];
  assign rd_k   = a_read_data[DIM_W-1:0];
  assign rd_n   = b_read_data[DIM_W-1:0];

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d        = state_q;
    a_read_addr_d  = a_read_addr_q;
    b_read_addr_d  = b_read_addr_q;
    result_we_d    = 1'b0;
    result_waddr_d = result_waddr_q;
    result_wdata_d = result_wdata_q;
    a_rows_d       = a_rows_q;
    a_cols_d       = a_cols_q;
    b_rows_d       = b_rows_q;
    b_cols_d       = b_cols_q;
    cur_row_d      = cur_row_q;
    cur_col_d      = cur_col_q;
    k_d            = k_q;
    acc_d          = acc_q;
    a_row_d        = a_row_q;
    b_col_d        = b_col_q;
    a_base_d       = a_base_q;
    b_base_d       = b_base_q;
    res_base_d     = res_base_q;
    start_elem     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mac_valid) begin
          a_base_d   = a_base_addr;
          b_base_d   = b_base_addr;
          res_base_d = result_base_addr;
          if (override_dims) begin
            a_rows_d = ovr_m;
            a_cols_d = ovr_k;
            b_rows_d = override_b_dims[DIM_W +: DIM_W];
            b_cols_d = ovr_n;
            // A degenerate product finishes without ever leaving idle
            if (ovr_m != '0 && ovr_k != '0 && ovr_n != '0) begin
              a_row_d    = a_base_addr;
              b_col_d    = b_base_addr;
              cur_row_d  = '0;
              cur_col_d  = '0;
              start_elem = 1'b1;
            end
          end else begin
            a_read_addr_d = '0;
            b_read_addr_d = '0;
            state_d       = S_DIM_RD;
          end
        end
      end
      S_DIM_RD: begin
        state_d = S_DIM_LATCH;
      end
      S_DIM_LATCH: begin
        a_rows_d = rd_m;
        a_cols_d = rd_k;
        b_rows_d = b_read_data[DIM_W +: DIM_W];
        b_cols_d = rd_n;
        if (rd_m != '0 && rd_k != '0 && rd_n != '0) begin
          a_row_d    = a_base_q;
          b_col_d    = b_base_q;
          cur_row_d  = '0;
          cur_col_d  = '0;
          start_elem = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Data arriving at k=0 belongs to the previous element, so discard it
        acc_d = (k_q == '0) ? '0 : acc_q + prod;
        if (k_q == a_cols_q - DIM_ONE) begin
          state_d = S_ACC;
        end else begin
          k_d           = k_q + DIM_ONE;
          a_read_addr_d = a_read_addr_q + ADDR_ONE;
          b_read_addr_d = b_read_addr_q + ADDR_ONE;
        end
      end
      S_ACC: begin
        result_wdata_d = acc_q + prod;
        result_we_d    = 1'b1;
        result_waddr_d = (cur_row_q == '0 && cur_col_q == '0) ? res_base_q
                                                              : result_waddr_q + ADDR_ONE;
        state_d        = S_WRITE;
      end
      S_WRITE: begin
        if (cur_col_q == b_cols_q - DIM_ONE) begin
          if (cur_row_q == a_rows_q - DIM_ONE) begin
            state_d = S_IDLE;
          end else begin
            cur_row_d  = cur_row_q + DIM_ONE;
            cur_col_d  = '0;
            a_row_d    = a_row_q + k_step;
            b_col_d    = b_base_q;
            start_elem = 1'b1;
          end
        end else begin
          cur_col_d  = cur_col_q + DIM_ONE;
          b_col_d    = b_col_q + k_step;
          start_elem = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every element begins by issuing the k=0 reads of its row and column
    if (start_elem) begin
      state_d       = S_RUN;
      k_d           = '0;
      a_read_addr_d = a_row_d;
      b_read_addr_d = b_col_d;
    end

    mac_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      mac_ready_q    <= 1'b1;
      a_read_addr_q  <= '0;
      b_read_addr_q  <= '0;
      result_we_q    <= 1'b0;
      result_waddr_q <= '0;
      result_wdata_q <= '0;
      a_rows_q       <= '0;
      a_cols_q       <= '0;
      b_rows_q       <= '0;
      b_cols_q       <= '0;
      cur_row_q      <= '0;
      cur_col_q      <= '0;
      k_q            <= '0;
      acc_q          <= '0;
      a_row_q        <= '0;
      b_col_q        <= '0;
      a_base_q       <= '0;
      b_base_q       <= '0;
      res_base_q     <= '0;
    end else begin
      state_q        <= state_d;
      mac_ready_q    <= mac_ready_d;
      a_read_addr_q  <= a_read_addr_d;
      b_read_addr_q  <= b_read_addr_d;
      result_we_q    <= result_we_d;
      result_waddr_q <= result_waddr_d;
      result_wdata_q <= result_wdata_d;
      a_rows_q       <= a_rows_d;
      a_cols_q       <= a_cols_d;
      b_rows_q       <= b_rows_d;
      b_cols_q       <= b_cols_d;
      cur_row_q      <= cur_row_d;
      cur_col_q      <= cur_col_d;
      k_q            <= k_d;
      acc_q          <= acc_d;
      a_row_q        <= a_row_d;
      b_col_q        <= b_col_d;
      a_base_q       <= a_base_d;
      b_base_q       <= b_base_d;
      res_base_q     <= res_base_d;
    end
  end

  assign mac_ready    = mac_ready_q;
  assign a_read_addr  = a_read_addr_q;
  assign b_read_addr  = b_read_addr_q;
  assign result_we    = result_we_q;
  assign result_waddr = result_waddr_q;
  assign result_wdata = result_wdata_q;
  assign a_rows       = a_rows_q;
  assign a_cols       = a_cols_q;
  assign b_rows       = b_rows_q;
  assign b_cols       = b_cols_q;
  assign cur_row      = cur_row_q;
  assign cur_col      = cur_col_q;

endmodule

// File: tb/tb_matmul_mac_engine.sv
// tb/tb_matmul_mac_engine.sv - directed scoreboard bench for matmul_mac_engine
module tb_matmul_mac_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mac_valid = 1'b0;
  logic        mac_ready;
  logic        override_dims = 1'b0;
  logic [31:0] override_a_dims = '0;
  logic [31:0] override_b_dims = '0;
  logic [15:0] a_base_addr = '0;
  logic [15:0] b_base_addr = '0;
  logic [15:0] result_base_addr = '0;
  logic [15:0] a_read_addr, b_read_addr;
  logic [31:0] a_read_data = '0;
  logic [31:0] b_read_data = '0;
  logic        result_we;
  logic [15:0] result_waddr;
  logic [31:0] result_wdata;
  logic [15:0] a_rows, a_cols, b_rows, b_cols, cur_row, cur_col;

  logic [31:0] a_mem [0:63];
  logic [31:0] b_mem [0:63];

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  bit no_addr0 = 1'b0;
  int busy;
  int wr_before;
  logic [15:0] next_b, next_r;

  matmul_mac_engine dut (
    .clk(clk), .reset_n(reset_n), .mac_valid(mac_valid), .mac_ready(mac_ready),
    .override_dims(override_dims), .override_a_dims(override_a_dims),
    .override_b_dims(override_b_dims), .a_base_addr(a_base_addr),
    .b_base_addr(b_base_addr), .result_base_addr(result_base_addr),
    .a_read_addr(a_read_addr), .a_read_data(a_read_data),
    .b_read_addr(b_read_addr), .b_read_data(b_read_data),
    .result_we(result_we), .result_waddr(result_waddr), .result_wdata(result_wdata),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .cur_row(cur_row), .cur_col(cur_col)
  );

  always #5 clk = ~clk;

  // SRAM models with one-cycle read latency
  always @(posedge clk) begin
    a_read_data <= a_mem[a_read_addr[5:0]];
    b_read_data <= b_mem[b_read_addr[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  // Reference C = A x B over the bench memories, A row-major and B column-major
  task automatic push_model(input int m_n, input int k_n, input int n_n,
                            input int ab, input int bb, input int rb);
    logic [31:0] acc;
    for (int m = 0; m < m_n; m++) begin
      for (int n = 0; n < n_n; n++) begin
        acc = '0;
        for (int k = 0; k < k_n; k++)
          acc = acc + a_mem[(ab + m * k_n + k) & 63] * b_mem[(bb + n * k_n + k) & 63];
        push(16'(rb + m * n_n + n), acc);
      end
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n && result_we) begin
      wr_count++;
      if (sb.size() == 0) begin
        check("unexpected_write", {31'd0, result_we}, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", {16'd0, result_waddr}, {16'd0, e.addr});
        check("write_data", result_wdata, e.data);
      end
    end
    if (reset_n && no_addr0 && !mac_ready) begin
      check("no_addr0", {31'd0, (a_read_addr != 16'd0 && b_read_addr != 16'd0)}, 32'd1);
    end
  end

  task automatic run_op(input logic ovr, input logic [31:0] ad, input logic [31:0] bd,
                        input logic [15:0] ab, input logic [15:0] bb, input logic [15:0] rb,
                        output int cyc);
    @(negedge clk);
    check("ready_before_start", {31'd0, mac_ready}, 32'd1);
    override_dims    = ovr;
    override_a_dims  = ad;
    override_b_dims  = bd;
    a_base_addr      = ab;
    b_base_addr      = bb;
    result_base_addr = rb;
    mac_valid        = 1'b1;
    @(posedge clk);
    #1;
    mac_valid = 1'b0;
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      if (mac_ready) break;
      cyc++;
    end
    check("ready_after_op", {31'd0, mac_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    a_mem[0] = 32'h0002_0003;
    b_mem[0] = 32'h0003_0002;
    a_mem[1] = 1; a_mem[2] = 2; a_mem[3] = 3;
    a_mem[4] = 4; a_mem[5] = 5; a_mem[6] = 6;
    b_mem[1] = 1; b_mem[2] = 0; b_mem[3] = 1;
    b_mem[4] = 0; b_mem[5] = 1; b_mem[6] = 32'hFFFF_FFFF;
    b_mem[7] = 2; b_mem[8] = 32'hFFFF_FFFF; b_mem[9] = 3;
    b_mem[10] = 5; b_mem[11] = 0; b_mem[12] = 32'hFFFF_FFFE;
    a_mem[20] = 32'hFFFF_FFF9; b_mem[20] = 3;
    a_mem[30] = 32'h7FFF_FFFF; a_mem[31] = 1;
    b_mem[30] = 1; b_mem[31] = 1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, mac_ready}, 32'd1);
    check("rst_we", {31'd0, result_we}, 32'd0);
    check("rst_a_addr", {16'd0, a_read_addr}, 32'd0);
    check("rst_waddr", {16'd0, result_waddr}, 32'd0);
    check("rst_wdata", result_wdata, 32'd0);
    check("rst_dims", {a_rows, b_cols}, 32'd0);
    check("rst_cur", {cur_row, cur_col}, 32'd0);
    reset_n = 1'b1;

    // 1: fetched dims, 2x3 times 3x2
    push(16'd0, 32'd4);
    push(16'd1, 32'hFFFF_FFFF);
    push(16'd2, 32'd10);
    push(16'd3, 32'hFFFF_FFFF);
    run_op(1'b0, 32'h0, 32'h0, 16'd1, 16'd1, 16'd0, busy);
    check("t1_busy", busy, 32'd22);
    check("t1_sb_empty", sb.size(), 32'd0);
    check("t1_b_addr", {16'd0, b_read_addr}, 32'd6);
    check("t1_a_addr", {16'd0, a_read_addr}, 32'd6);
    check("t1_waddr", {16'd0, result_waddr}, 32'd3);
    check("t1_dims_a", {a_rows, a_cols}, 32'h0002_0003);
    check("t1_dims_b", {b_rows, b_cols}, 32'h0003_0002);
    check("t1_cur", {cur_row, cur_col}, 32'h0001_0001);

    // 6: chain using the held addresses as next bases
    next_b = b_read_addr + 16'd1;
    next_r = result_waddr + 16'd1;
    push_model(2, 3, 2, 1, 7, 4);
    run_op(1'b1, 32'h0002_0003, 32'h0003_0002, 16'd1, next_b, next_r, busy);
    check("t6_busy", busy, 32'd20);
    check("t6_sb_empty", sb.size(), 32'd0);
    check("t6_waddr", {16'd0, result_waddr}, 32'd7);

    // 2: override 1x1, signed product
    wr_before = wr_count;
    push(16'd10, 32'hFFFF_FFEB);
    no_addr0 = 1'b1;
    run_op(1'b1, 32'h0001_0001, 32'h0001_0001, 16'd20, 16'd20, 16'd10, busy);
    no_addr0 = 1'b0;
    check("t2_busy", busy, 32'd3);
    check("t2_writes", wr_count - wr_before, 32'd1);
    check("t2_sb_empty", sb.size(), 32'd0);

    // 3: accumulator wrap
    push(16'd20, 32'h8000_0000);
    run_op(1'b1, 32'h0001_0002, 32'h0002_0001, 16'd30, 16'd30, 16'd20, busy);
    check("t3_busy", busy, 32'd4);
    check("t3_sb_empty", sb.size(), 32'd0);

    // 4: M=0 finishes with no busy time and no writes
    wr_before = wr_count;
    run_op(1'b1, 32'h0000_0003, 32'h0003_0002, 16'd1, 16'd1, 16'd50, busy);
    check("t4_busy", busy, 32'd0);
    check("t4_writes", wr_count - wr_before, 32'd0);

    // 5a: mac_valid held high gives one op then an immediate restart
    push(16'd10, 32'hFFFF_FFEB);
    push(16'd10, 32'hFFFF_FFEB);
    wr_before = wr_count;
    @(negedge clk);
    override_dims    = 1'b1;
    override_a_dims  = 32'h0001_0001;
    override_b_dims  = 32'h0001_0001;
    a_base_addr      = 16'd20;
    b_base_addr      = 16'd20;
    result_base_addr = 16'd10;
    mac_valid        = 1'b1;
    @(posedge clk);
    busy = 0;
    while (busy < 2000) begin
      @(negedge clk);
      if (mac_ready) break;
      busy++;
    end
    check("t5_first_busy", busy, 32'd3);
    check("t5_first_writes", wr_count - wr_before, 32'd1);
    @(posedge clk);
    #1;
    mac_valid = 1'b0;
    @(negedge clk);
    check("t5_restart", {31'd0, mac_ready}, 32'd0);
    busy = 0;
    while (busy < 2000 && !mac_ready) begin
      @(negedge clk);
      busy++;
    end
    check("t5_second_done", {31'd0, mac_ready}, 32'd1);
    check("t5_sb_empty", sb.size(), 32'd0);

    // 5b: reset during RUN aborts asynchronously
    wr_before = wr_count;
    @(negedge clk);
    override_a_dims  = 32'h0002_0003;
    override_b_dims  = 32'h0003_0002;
    a_base_addr      = 16'd1;
    b_base_addr      = 16'd1;
    result_base_addr = 16'd40;
    mac_valid        = 1'b1;
    @(posedge clk);
    #1;
    mac_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_run", {31'd0, mac_ready}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_ready", {31'd0, mac_ready}, 32'd1);
    check("t5_rst_we", {31'd0, result_we}, 32'd0);
    check("t5_rst_a_addr", {16'd0, a_read_addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_writes", wr_count - wr_before, 32'd0);
    check("t5_idle", {31'd0, mac_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_mac_engine.md
Name: matmul_mac_engine

Overview:
Sequential matrix-multiply engine used by the attention top-level for every Q/K/V/S/Z product. It computes C = A x B and writes C row-major into result SRAM. A is streamed from the A read port, which the top-level muxes between the input and result SRAMs. B is streamed from the B read port, which the top-level muxes between the weight and scratchpad SRAMs. It exposes dimensions, current row/col and its final read/write addresses so the controller can chain operations and build transposed scratchpad copies.

Parameters:
DATA_W, 32, SRAM data width; operand, accumulator and result width.
ADDR_W, 16, SRAM address width.
DIM_W, 16, width of each dimension field; dimension word = {rows[31:16], cols[15:0]}.

Ports:
clk  input  1  clock
reset_n  input  1  async active-low reset
mac_valid  input  1  start request; sampled only when mac_ready=1
mac_ready  output  1  1 = idle/accepting; 0 = busy
override_dims  input  1  sampled with accepted mac_valid; 1 = use override words and skip dimension fetch
override_a_dims  input  DATA_W  {A rows, A cols}
override_b_dims  input  DATA_W  {B rows, B cols}
a_base_addr  input  ADDR_W  address of A element (0,0); latched at start
b_base_addr  input  ADDR_W  address of B element (0,0); latched at start
result_base_addr  input  ADDR_W  address of C element (0,0); latched at start
a_read_addr  output  ADDR_W  A read address
a_read_data  input  DATA_W  A data; valid one cycle after address
b_read_addr  output  ADDR_W  B read address
b_read_data  input  DATA_W  B data; valid one cycle after address
result_we  output  1  result write enable
result_waddr  output  ADDR_W  result write address
result_wdata  output  DATA_W  result write data
a_rows, a_cols, b_rows, b_cols  output  DIM_W each  latched dimensions
cur_row, cur_col  output  DIM_W each  (m,n) of the element being computed or last written

Behaviour:
- Reset values (async, all outputs registered): mac_ready=1; result_we=0; all addresses 0; result_wdata 0; dims 0; cur_row/cur_col 0; state IDLE.
- Dimension mapping: M=a_rows, K=a_cols, N=b_cols. b_rows is reported only and never checked.
- Storage layout: A(m,k) at a_base+m*K+k. B(k,n) at b_base+n*K+k (column-major). C(m,n) written to result_base+m*N+n.
- Arithmetic: signed two's-complement multiply; accumulate truncated to DATA_W with wrap; no saturation.
- All address arithmetic is modulo 2^ADDR_W.
- States:
  - IDLE: mac_ready=1. On mac_valid, latch bases and override_dims.
    - override_dims=1: latch both override words, go to RUN.
    - override_dims=0: go to DIM_RD.
  - DIM_RD: drive a_read_addr=0 and b_read_addr=0; go to DIM_LATCH.
  - DIM_LATCH: latch a_read_data into a_rows/a_cols and b_read_data into b_rows/b_cols; go to RUN.
  - Zero check on entry to RUN: if M, K or N is 0, go to IDLE with no writes.
  - RUN: issue A(m,k) and B(k,n) reads for k=0..K-1 on consecutive cycles. Each cycle accumulates the product returned for the read issued the previous cycle; the accumulator is cleared at k=0 of each element. After k=K-1, go to ACC.
  - ACC: add the final product; go to WRITE.
  - WRITE: result_we=1 for exactly one cycle, with result_waddr and result_wdata registered.
    - If more elements remain, advance n (then m when n wraps) and return to RUN.
    - Else go to IDLE.
- mac_ready falls the cycle after acceptance and rises the cycle after the last WRITE.
- Per element: K+2 cycles. Busy time = (override ? 0 : 2) + M*N*(K+2) cycles.
- Hold on completion: after completion and while idle, a_read_addr and b_read_addr hold the last issued addresses, result_waddr holds the last written address, and dims and cur_row/cur_col hold their values. The controller uses these +1 as next bases.
- cur_row/cur_col update at the start of each element's RUN.
- mac_valid while busy is ignored; override inputs and bases are ignored after acceptance.
- Reset mid-operation aborts immediately to the reset values; no further writes are issued.

Test Plan:
1. No override. Dims words A=0x0002_0003, B=0x0003_0002. A rows [1 2 3],[4 5 6] at base 1. B columns [1,0,1],[0,1,-1] at base 1. result_base 0. -> writes 4, -1, 10, -1 to addresses 0..3; busy 22 cycles; afterwards b_read_addr=6 and result_waddr=3.
2. Override 1x1 (A=0x0001_0001, B=0x0001_0001), A=-7, B=3 -> exactly one write of 0xFFFF_FFEB; busy 3 cycles; no reads of address 0.
3. Overflow: K=2, A=[0x7FFF_FFFF,1], B=[1,1] -> result 0x8000_0000, showing wrap.
4. Override with M=0 -> mac_ready returns 1 the cycle after acceptance; result_we never asserted.
5. mac_valid held high for the whole run -> exactly one operation, then an immediate restart when mac_ready=1. Reset asserted during RUN -> mac_ready=1 and result_we=0 asynchronously.
6. Chained runs (Q then K weights): second start with b_base = previous b_read_addr+1 and result_base = previous result_waddr+1 -> results stored contiguously with no gaps or overlap.
